mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 1, memory read latency in cycles after the access cycle; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  instruction-fetch request; held high until i_done.
REQ-005 i_addr  input  32  fetch address; stable while i_req is high.
REQ-006 i_done  output  1  one-cycle pulse; i_rdata valid in the same cycle.
REQ-007 i_rdata  output  32  fetched word; holds its value until the next fetch completes.
REQ-008 d_req  input  1  data request; held high until d_done.
REQ-009 d_we  input  1  1 = store, 0 = load; stable while d_req is high.
REQ-010 d_addr  input  32  data address; stable while d_req is high.
REQ-011 d_wdata  input  32  store data; stable while d_req is high.
REQ-012 d_done  output  1  one-cycle pulse; d_rdata valid in the same cycle for loads.
REQ-013 d_rdata  output  32  load word; holds its value until the next load completes.
REQ-014 mem_en  output  1  memory access strobe, high for exactly one cycle per transaction.
REQ-015 mem_we  output  1  memory write enable; high only when mem_en=1 and the owner is data with d_we=1.
REQ-016 mem_addr  output  32  owner address while mem_en=1; 0 otherwise.
REQ-017 mem_wdata  output  32  d_wdata while mem_we=1; 0 otherwise.
REQ-018 mem_rdata  input  32  memory read data, valid LATENCY cycles after the mem_en cycle.

Function
REQ-019 The state machine SHALL have four states: IDLE, ACCESS, WAIT, RESP.
REQ-020 IDLE: if any request is high, the block SHALL register the winner as owner and go to ACCESS; otherwise it stays in IDLE.
REQ-021 ACCESS: the block SHALL assert mem_en for one cycle with the owner's signals, load the wait counter with LATENCY-1, and go to WAIT.
REQ-022 WAIT: the counter SHALL decrement each cycle; at 0 the block SHALL capture mem_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
REQ-023 RESP: the block SHALL pulse the owner's done for one cycle and return to IDLE unconditionally.
REQ-024 Latency from first IDLE cycle with a request to the done pulse SHALL be LATENCY+2 cycles.
REQ-025 Stores SHALL leave d_rdata unchanged.
REQ-026 Requests are sampled only in IDLE; any request that drops mid-transaction SHALL NOT abort it, and done still pulses.
REQ-027 Default arbitration is fixed priority: data wins when i_req and d_req are both high.
REQ-028 Back-to-back transactions SHALL have one IDLE cycle between RESP and the next ACCESS.
REQ-029 i_done and d_done SHALL never be high in the same cycle.

Reset
REQ-030 Reset SHALL force IDLE on the next edge and abandon any in-flight transaction without a done pulse.
REQ-031 Reset SHALL set the following to 0:
- mem_en, mem_we, mem_addr, mem_wdata
- i_done, d_done, i_rdata, d_rdata
- wait counter
- owner
REQ-032 Reset SHALL set the round-robin last-owner pointer to instruction.

Configuration
REQ-033 With macro ARB_ROUND_ROBIN_EN defined, a tie in IDLE SHALL go to the requester that did not own the previous transaction; the pointer updates on entry to ACCESS.
REQ-034 Without ARB_ROUND_ROBIN_EN, REQ-027 fixed priority applies and no pointer register SHALL be synthesized.

Verification
REQ-035 LATENCY=1, fetch i_addr=0x00000010, memory returns 0x00500093:
- mem_en high exactly 1 cycle with mem_addr=0x10
- i_done 3 cycles after the request with i_rdata=0x00500093
REQ-036 Store d_addr=0x20, d_wdata=0xDEADBEEF:
- mem_we=1, mem_wdata=0xDEADBEEF in the ACCESS cycle
- d_done pulses, d_rdata unchanged
REQ-037 i_req and d_req raised in the same cycle, fixed priority:
- data served first, instruction second
- second ACCESS starts 1 cycle after the first RESP
REQ-038 ARB_ROUND_ROBIN_EN, both requests held high for 4 transactions:
- owners alternate D, I, D, I starting from reset
REQ-039 LATENCY=3, reset asserted during WAIT:
- IDLE next cycle
- no done pulse, all outputs 0
- a new fetch completes normally in 5 cycles
REQ-040 Load requested while a fetch is in WAIT:
- the load waits
- mem_en never overlaps
- i_done and d_done never coincide

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one memory with fixed read latency.
// Define ARB_ROUND_ROBIN_EN to break ties round-robin instead of data-first.
module mem_arbiter #(
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_done,
   output logic [31:0] i_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_done,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_owner;      // 1 = data port owns the transaction
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_cnt;
   logic [31:0] r_i_rdata;
   logic [31:0] r_d_rdata;
   logic        w_grant_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_d;

   // On a tie, hand the bus to whoever did not have it last time.
   assign w_grant_d = d_req && (!i_req || !r_last_d);

   always_ff @(posedge clk) begin
      if (reset)
         r_last_d <= 1'b0;
      else if (r_state == S_IDLE && (i_req || d_req))
         r_last_d <= w_grant_d;
   end
`else
   assign w_grant_d = d_req;
`endif

   always_comb begin
      w_next    = r_state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      case (r_state)
         S_IDLE:   if (i_req || d_req) w_next = S_ACCESS;
         S_ACCESS: begin
            w_next   = S_WAIT;
            mem_en   = 1'b1;
            mem_we   = r_we;
            mem_addr = r_addr;
            if (r_we) mem_wdata = r_wdata;
         end
         S_WAIT:   if (r_cnt == 4'd0) w_next = S_RESP;
         S_RESP: begin
            w_next = S_IDLE;
            i_done = !r_owner;
            d_done = r_owner;
         end
         default:  w_next = S_IDLE;
      endcase
   end

   // Request fields are latched at grant so a requester may drop mid-flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_owner   <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= 32'd0;
         r_wdata   <= 32'd0;
         r_cnt     <= 4'd0;
         r_i_rdata <= 32'd0;
         r_d_rdata <= 32'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: if (i_req || d_req) begin
               r_owner <= w_grant_d;
               r_we    <= w_grant_d && d_we;
               r_addr  <= w_grant_d ? d_addr : i_addr;
               r_wdata <= w_grant_d ? d_wdata : 32'd0;
            end
            S_ACCESS: r_cnt <= 4'(LATENCY - 1);
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  if (!r_owner)  r_i_rdata <= mem_rdata;
                  else if (!r_we) r_d_rdata <= mem_rdata;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign i_rdata = r_i_rdata;
   assign d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a timestamp model predicts each grant,
// bus cycle and done pulse; a negedge monitor compares against the DUT.
module tb_mem_arbiter;
   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
   logic        i_done, d_done, mem_en, mem_we;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

   mem_arbiter #(.LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          own_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          en_c;
      int          done_c;
   } exp_t;

   exp_t        q[$];
   exp_t        h;
   logic [31:0] rd_sched[int];
   int          free_c = 0;
   bit          rr_last_d = 1'b0;
   logic [31:0] last_i = '0, last_d = '0;
   bit          i_seen = 1'b0, d_seen = 1'b0, mon_on = 1'b0;
   bit          e_en, e_id, e_dd, wd;
   int          n_vec = 0, n_bad = 0;

   function automatic logic [31:0] memf(logic [31:0] a);
      return a ^ 32'h0050_0083;   // 0x10 -> 0x00500093
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // Monitor + reference model
   always @(negedge clk) begin
      if (mon_on) begin
         e_en = 1'b0; e_id = 1'b0; e_dd = 1'b0;
         if (q.size() > 0) begin
            h    = q[0];
            e_en = (h.en_c == cyc);
            if (h.done_c == cyc) begin
               if (h.own_d) e_dd = 1'b1; else e_id = 1'b1;
               if (!h.own_d)   last_i = h.rdata;
               else if (!h.we) last_d = h.rdata;
            end
         end
         chk("mem_en", {31'd0, mem_en}, {31'd0, e_en});
         chk("mem_we", {31'd0, mem_we}, {31'd0, e_en && h.we});
         chk("mem_addr", mem_addr, e_en ? h.addr : 32'd0);
         chk("mem_wdata", mem_wdata, (e_en && h.we) ? h.wdata : 32'd0);
         chk("i_done", {31'd0, i_done}, {31'd0, e_id});
         chk("d_done", {31'd0, d_done}, {31'd0, e_dd});
         chk("i_rdata", i_rdata, last_i);
         chk("d_rdata", d_rdata, last_d);
         chk("done_overlap", {31'd0, i_done && d_done}, 32'd0);
         if (q.size() > 0 && q[0].done_c == cyc) void'(q.pop_front());
         i_seen = i_done;
         d_seen = d_done;
         if (mem_en && !mem_we) rd_sched[cyc + LAT] = memf(mem_addr);
         if (reset) begin
            q.delete();
            last_i = '0; last_d = '0; rr_last_d = 1'b0;
            free_c = cyc + 1;
         end else if (cyc >= free_c && (i_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
            wd = d_req && (!i_req || !rr_last_d);
            rr_last_d = wd;
`else
            wd = d_req;
`endif
            h.own_d  = wd;
            h.we     = wd && d_we;
            h.addr   = wd ? d_addr : i_addr;
            h.wdata  = d_wdata;
            h.rdata  = memf(h.addr);
            h.en_c   = cyc + 1;
            h.done_c = cyc + LAT + 2;
            q.push_back(h);
            free_c   = cyc + LAT + 3;   // done cycle, then one idle cycle
         end
      end
   end

   // Advance one cycle; requesters drop after their done, memory drives data.
   task automatic step();
      @(posedge clk); #1;
      if (i_req && i_seen) i_req = 1'b0;
      if (d_req && d_seen) d_req = 1'b0;
      mem_rdata = rd_sched.exists(cyc) ? rd_sched[cyc] : $urandom;
   endtask

   task automatic drain(int budget);
      int k = 0;
      while ((i_req || d_req || q.size() > 0) && k < budget) begin
         step();
         k++;
      end
      n_vec++;
      if (k >= budget) begin
         n_bad++;
         $display("FAIL drain_timeout cyc=%0d got=%0d cycles expected<%0d", cyc, k, budget);
         i_req = 1'b0; d_req = 1'b0;
      end
      step(); step();
   endtask

   task automatic rnd_step();
      step();
      if (!i_req) begin
         if ($urandom_range(3) == 0) begin
            i_req = 1'b1; i_addr = {$urandom} & 32'hFFFF_FFFC;
         end
      end else if ($urandom_range(31) == 0) i_req = 1'b0;
      if (!d_req) begin
         if ($urandom_range(3) == 0) begin
            d_req = 1'b1; d_we = $urandom_range(1) == 1;
            d_addr = {$urandom} & 32'hFFFF_FFFC; d_wdata = $urandom;
         end
      end else if ($urandom_range(31) == 0) d_req = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      step(); mon_on = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
      // single fetch
      i_addr = 32'h10; i_req = 1'b1; drain(40);
      // single store
      d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF; d_we = 1'b1; d_req = 1'b1; drain(40);
      d_we = 1'b0;
      // simultaneous requests
      i_addr = 32'h44; d_addr = 32'h80; i_req = 1'b1; d_req = 1'b1; drain(60);
      // reset while the fetch sits in WAIT; request stays up through reset
      i_addr = 32'h100; i_req = 1'b1;
      step(); step(); step();
      reset = 1'b1; step(); reset = 1'b0;
      drain(40);
      // load raised while a fetch is waiting on memory
      i_addr = 32'h200; i_req = 1'b1;
      step(); step();
      d_addr = 32'h204; d_req = 1'b1; drain(60);
      // both held high across four transactions
      i_addr = 32'h300; d_addr = 32'h400;
      i_req = 1'b1; d_req = 1'b1;
      repeat (4 * (LAT + 3)) begin
         step(); i_req = 1'b1; d_req = 1'b1;
      end
      i_req = 1'b0; d_req = 1'b0; drain(40);
      // random traffic, with an occasional reset
      repeat (4000) begin
         rnd_step();
         if ($urandom_range(499) == 0) begin
            reset = 1'b1; step(); reset = 1'b0;
         end
      end
      i_req = 1'b0; d_req = 1'b0; drain(40);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d got=no_finish expected=finish", cyc);
      $fatal(1, "watchdog");
   end
endmodule
